dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data memory between the pipeline MEM stage (CPU port) and the program loader/debug port (LDR port).
//  Sits between the MEM stage and data_mem: muxes address/write data/write enable and returns read data to the winner.
//  Drives cpu_stall back to the hazard logic when the CPU loses arbitration.
//  CPU has priority; a wait counter bounds loader starvation; a lock mode gives the loader exclusive access for bulk loads.
// PARAMETERS
//  ADDR_W    32  address width of both ports and memory
//  DATA_W    32  data width
//  MAX_WAIT  4   consecutive lost cycles after which a pending loader request wins over the CPU (>=1)
//  CNT_W     16  width of the stall-cycle statistics counter
// PORTS
//  clk           in   1       single clock, all state updates on rising edge
//  reset         in   1       synchronous, active-high
//  cpu_req       in   1       MEM stage access this cycle (load or store)
//  cpu_wr        in   1       1 = store, 0 = load
//  cpu_addr      in   ADDR_W  CPU address (ALU result)
//  cpu_wr_data   in   DATA_W  CPU store data
//  cpu_rd_data   out  DATA_W  load data, combinational from mem_rd_data
//  cpu_stall     out  1       CPU access not performed this cycle; pipeline must hold
//  ldr_req       in   1       loader access request, held until ldr_ack
//  ldr_wr        in   1       1 = write, 0 = read
//  ldr_addr      in   ADDR_W  loader address
//  ldr_wr_data   in   DATA_W  loader write data
//  ldr_lock      in   1       request exclusive ownership (lock mode)
//  ldr_ack       out  1       registered; access completed in previous cycle
//  ldr_rd_data   out  DATA_W  registered read data, valid with ldr_ack
//  ldr_locked    out  1       1 while in lock mode
//  mem_wr_en     out  1       to data_mem write enable
//  mem_addr      out  ADDR_W  to data_mem address
//  mem_wr_data   out  DATA_W  to data_mem write data
//  mem_rd_data   in   DATA_W  from data_mem (asynchronous read)
//  stall_cnt     out  CNT_W   saturating count of cycles with cpu_stall=1
// BEHAVIOUR
//  Reset: state=S_NORM, wait_cnt=0, ldr_ack=0, ldr_rd_data=0, ldr_locked=0, stall_cnt=0.
//  Grant (combinational, same cycle):
//   gnt_ldr = ldr_req & (state==S_LOCK | ~cpu_req | wait_cnt==MAX_WAIT)
//   gnt_cpu = cpu_req & ~gnt_ldr & state==S_NORM
//   cpu_stall = cpu_req & ~gnt_cpu
//  Mux: gnt_ldr selects ldr_addr/ldr_wr_data, else cpu_addr/cpu_wr_data; mem_wr_en = (gnt_ldr&ldr_wr)|(gnt_cpu&cpu_wr); no grant -> mem_wr_en=0.
//  Single-cycle access: a write commits at the edge ending the grant cycle; reads are sampled in the grant cycle.
//  ldr_ack <= gnt_ldr; ldr_rd_data <= mem_rd_data when gnt_ldr (held otherwise). Loader drops/changes request after seeing ldr_ack.
//  wait_cnt: cleared when gnt_ldr or ~ldr_req; else +1, saturating at MAX_WAIT.
//  FSM: S_NORM -> S_LOCK at edge where ldr_lock=1; S_LOCK -> S_NORM at edge where ldr_lock=0. ldr_locked = (state==S_LOCK).
//   In S_LOCK every cpu_req is stalled; loader granted whenever ldr_req. Lock exit re-enables CPU the cycle after ldr_lock falls.
//  Simultaneous CPU+LDR in S_NORM with wait_cnt<MAX_WAIT: CPU wins, loader waits (no ack).
//  stall_cnt +1 each cycle cpu_stall=1, saturates at all-ones.
//  Reset mid-access: any in-flight write that cycle still follows mem_wr_en as driven; all state returns to reset values.
// STRUCTURE
//  Shared package: state encoding (S_NORM, S_LOCK) and default MAX_WAIT constant.
//  Registers via existing d_ff where convenient (ldr_ack, ldr_rd_data); no sub-module needed beyond the grant/mux logic.
// TESTING
//  CPU only: store 0xDEADBEEF @0x10, then load @0x10 -> cpu_stall=0 both cycles, cpu_rd_data=0xDEADBEEF.
//  LDR only: write 0x12345678 @0x20 -> ldr_ack=1 next cycle; LDR read @0x20 -> ldr_rd_data=0x12345678 with ack.
//  Contention, MAX_WAIT=4: cpu_req and ldr_req high continuously -> CPU granted 4 cycles, loader 5th cycle, cpu_stall=1 only then, stall_cnt=1.
//  Lock: ldr_lock=1 with cpu_req high -> cpu_stall=1 from next cycle, ldr_locked=1; drop lock -> cpu_stall=0 one cycle later.
//  Reset asserted during contention (wait_cnt=3) -> next cycle wait_cnt=0, ldr_ack=0, stall_cnt=0, S_NORM.
//  No requests -> mem_wr_en=0, no ack, counters unchanged.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and wait-counter sizing.
package dmem_arbiter_pkg;

  typedef enum logic {
    S_NORM = 1'b0,
    S_LOCK = 1'b1
  } arb_state_t;

  localparam int DEFAULT_MAX_WAIT = 4;

  function automatic int wait_cnt_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_grant.sv
// Combinational grant decision and memory-side mux between the CPU and loader ports.
module dmem_arbiter_grant
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  arb_state_t        i_state,
  input  logic              i_wait_full,
  input  logic              i_cpu_req,
  input  logic              i_cpu_wr,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wr_data,
  input  logic              i_ldr_req,
  input  logic              i_ldr_wr,
  input  logic [ADDR_W-1:0] i_ldr_addr,
  input  logic [DATA_W-1:0] i_ldr_wr_data,
  output logic              o_gnt_ldr,
  output logic              o_gnt_cpu,
  output logic              o_cpu_stall,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wr_data
);

  // Loader wins when locked, when the CPU is idle, or once it has starved long enough.
  assign o_gnt_ldr     = i_ldr_req & ((i_state == S_LOCK) | ~i_cpu_req | i_wait_full);
  assign o_gnt_cpu     = i_cpu_req & ~o_gnt_ldr & (i_state == S_NORM);
  assign o_cpu_stall   = i_cpu_req & ~o_gnt_cpu;

  assign o_mem_addr    = o_gnt_ldr ? i_ldr_addr    : i_cpu_addr;
  assign o_mem_wr_data = o_gnt_ldr ? i_ldr_wr_data : i_cpu_wr_data;
  assign o_mem_wr_en   = (o_gnt_ldr & i_ldr_wr) | (o_gnt_cpu & i_cpu_wr);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares data memory between the MEM stage and the loader/debug port; CPU has priority,
// bounded loader starvation, and a lock mode giving the loader exclusive access.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_wr,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wr_data,
  output logic [DATA_W-1:0] o_cpu_rd_data,
  output logic              o_cpu_stall,
  input  logic              i_ldr_req,
  input  logic              i_ldr_wr,
  input  logic [ADDR_W-1:0] i_ldr_addr,
  input  logic [DATA_W-1:0] i_ldr_wr_data,
  input  logic              i_ldr_lock,
  output logic              o_ldr_ack,
  output logic [DATA_W-1:0] o_ldr_rd_data,
  output logic              o_ldr_locked,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wr_data,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam int WAIT_W = wait_cnt_width(MAX_WAIT);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_ldr_ack;
  logic [DATA_W-1:0] r_ldr_rd_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_wait_full;
  logic              w_gnt_ldr;
  logic              w_gnt_cpu;
  logic              w_cpu_stall;

  assign w_wait_full = (r_wait_cnt == WAIT_W'(MAX_WAIT));

  dmem_arbiter_grant #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_grant (
    .i_state      (r_state),
    .i_wait_full  (w_wait_full),
    .i_cpu_req    (i_cpu_req),
    .i_cpu_wr     (i_cpu_wr),
    .i_cpu_addr   (i_cpu_addr),
    .i_cpu_wr_data(i_cpu_wr_data),
    .i_ldr_req    (i_ldr_req),
    .i_ldr_wr     (i_ldr_wr),
    .i_ldr_addr   (i_ldr_addr),
    .i_ldr_wr_data(i_ldr_wr_data),
    .o_gnt_ldr    (w_gnt_ldr),
    .o_gnt_cpu    (w_gnt_cpu),
    .o_cpu_stall  (w_cpu_stall),
    .o_mem_wr_en  (o_mem_wr_en),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wr_data(o_mem_wr_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_NORM;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_NORM:  if (i_ldr_lock)  w_state_next = S_LOCK;
      S_LOCK:  if (!i_ldr_lock) w_state_next = S_NORM;
      default: w_state_next = S_NORM;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wait_cnt    <= '0;
      r_ldr_ack     <= 1'b0;
      r_ldr_rd_data <= '0;
      r_stall_cnt   <= '0;
    end else begin
      r_ldr_ack <= w_gnt_ldr;
      if (w_gnt_ldr) r_ldr_rd_data <= i_mem_rd_data;
      // Starvation counter only runs while the loader is actually waiting.
      if (w_gnt_ldr || !i_ldr_req) r_wait_cnt <= '0;
      else if (!w_wait_full)       r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_cpu_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_cpu_rd_data = i_mem_rd_data;
  assign o_cpu_stall   = w_cpu_stall;
  assign o_ldr_ack     = r_ldr_ack;
  assign o_ldr_rd_data = r_ldr_rd_data;
  assign o_ldr_locked  = (r_state == S_LOCK);
  assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a small asynchronous-read memory model.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_wr;
  logic [31:0] cpu_addr, cpu_wr_data, cpu_rd_data;
  logic        cpu_stall;
  logic        ldr_req, ldr_wr, ldr_lock;
  logic [31:0] ldr_addr, ldr_wr_data, ldr_rd_data;
  logic        ldr_ack, ldr_locked;
  logic        mem_wr_en;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        stall;
    logic        wren;
    logic        locked;
    logic [15:0] sc;
    logic        chk_rd;
    logic [31:0] rd;
  } cyc_t;

  typedef struct {
    string       tag;
    logic        chk_data;
    logic [31:0] data;
  } ack_t;

  cyc_t cyc_q[$];
  ack_t ack_q[$];

  logic [31:0] tb_mem [0:255];

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .CNT_W(16)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_cpu_req(cpu_req), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr),
    .i_cpu_wr_data(cpu_wr_data), .o_cpu_rd_data(cpu_rd_data), .o_cpu_stall(cpu_stall),
    .i_ldr_req(ldr_req), .i_ldr_wr(ldr_wr), .i_ldr_addr(ldr_addr),
    .i_ldr_wr_data(ldr_wr_data), .i_ldr_lock(ldr_lock), .o_ldr_ack(ldr_ack),
    .o_ldr_rd_data(ldr_rd_data), .o_ldr_locked(ldr_locked),
    .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr), .o_mem_wr_data(mem_wr_data),
    .i_mem_rd_data(mem_rd_data), .o_stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_data = (mem_addr[31:8] == 24'h0) ? tb_mem[mem_addr[7:0]] : 32'h0;
  always @(posedge clk)
    if (mem_wr_en && (mem_addr[31:8] == 24'h0)) tb_mem[mem_addr[7:0]] <= mem_wr_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every cycle's outputs and each loader acknowledge.
  always @(negedge clk) begin
    cyc_t c;
    ack_t a;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      check({c.tag, " cpu_stall"}, {31'b0, cpu_stall}, {31'b0, c.stall});
      check({c.tag, " mem_wr_en"}, {31'b0, mem_wr_en}, {31'b0, c.wren});
      check({c.tag, " ldr_locked"}, {31'b0, ldr_locked}, {31'b0, c.locked});
      check({c.tag, " stall_cnt"}, {16'b0, stall_cnt}, {16'b0, c.sc});
      if (c.chk_rd) check({c.tag, " cpu_rd_data"}, cpu_rd_data, c.rd);
      $display("cycle %-12s stall=%0b wr_en=%0b locked=%0b stall_cnt=%0d ack=%0b",
               c.tag, cpu_stall, mem_wr_en, ldr_locked, stall_cnt, ldr_ack);
    end
    if (ldr_ack === 1'b1) begin
      if (ack_q.size() == 0) begin
        check("unexpected ldr_ack", 32'd1, 32'd0);
      end else begin
        a = ack_q.pop_front();
        check({a.tag, " ldr_ack"}, {31'b0, ldr_ack}, 32'd1);
        if (a.chk_data) check({a.tag, " ldr_rd_data"}, ldr_rd_data, a.data);
      end
    end
  end

  task automatic drive(input string tag,
                       input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
                       input logic lk, input logic rst,
                       input logic e_stall, input logic e_wren, input logic e_lock, input logic [15:0] e_sc,
                       input logic e_chk, input logic [31:0] e_rd,
                       input logic e_ack, input logic e_ack_chk, input logic [31:0] e_ack_d);
    cyc_t c;
    ack_t a;
    @(posedge clk);
    #1;
    cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wr_data = cd;
    ldr_req = lr; ldr_wr = lw; ldr_addr = la; ldr_wr_data = ld;
    ldr_lock = lk; reset = rst;
    c.tag = tag; c.stall = e_stall; c.wren = e_wren; c.locked = e_lock;
    c.sc = e_sc; c.chk_rd = e_chk; c.rd = e_rd;
    cyc_q.push_back(c);
    if (e_ack) begin
      a.tag = tag; a.chk_data = e_ack_chk; a.data = e_ack_d;
      ack_q.push_back(a);
    end
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
    reset = 1'b1;
    cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wr_data = 0;
    ldr_req = 0; ldr_wr = 0; ldr_addr = 0; ldr_wr_data = 0; ldr_lock = 0;
    repeat (2) @(posedge clk);

    //     tag           cr cw addr   wdata         lr lw addr   wdata        lk rst  stl wen lck sc chk rd            ack chk data
    drive("idle_rst",    0, 0, Z,     Z,            0, 0, Z,     Z,           0, 0,   0,  0,  0,  0, 0, Z,            0, 0, Z);
    drive("cpu_st",      1, 1, 32'h10, 32'hDEADBEEF, 0, 0, Z,    Z,           0, 0,   0,  1,  0,  0, 0, Z,            0, 0, Z);
    drive("cpu_ld",      1, 0, 32'h10, Z,           0, 0, Z,     Z,           0, 0,   0,  0,  0,  0, 1, 32'hDEADBEEF, 0, 0, Z);
    drive("ldr_wr",      0, 0, Z,     Z,            1, 1, 32'h20, 32'h12345678, 0, 0, 0,  1,  0,  0, 0, Z,            1, 0, Z);
    drive("idle1",       0, 0, Z,     Z,            0, 0, Z,     Z,           0, 0,   0,  0,  0,  0, 0, Z,            0, 0, Z);
    drive("ldr_rd",      0, 0, Z,     Z,            1, 0, 32'h20, Z,          0, 0,   0,  0,  0,  0, 1, 32'h12345678, 1, 1, 32'h12345678);
    drive("idle2",       0, 0, Z,     Z,            0, 0, Z,     Z,           0, 0,   0,  0,  0,  0, 0, Z,            0, 0, Z);
    // Contention: CPU wins while wait_cnt is 0..3, loader wins at 4.
    drive("cont_w0",     1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 0,   0,  0,  0,  0, 1, 32'hDEADBEEF, 0, 0, Z);
    drive("cont_w1",     1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 0,   0,  0,  0,  0, 1, 32'hDEADBEEF, 0, 0, Z);
    drive("cont_w2",     1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 0,   0,  0,  0,  0, 1, 32'hDEADBEEF, 0, 0, Z);
    drive("cont_w3",     1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 0,   0,  0,  0,  0, 1, 32'hDEADBEEF, 0, 0, Z);
    drive("cont_w4",     1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 0,   1,  0,  0,  0, 0, Z,            1, 1, 32'h12345678);
    drive("cont_after",  1, 0, 32'h10, Z,           0, 0, Z,     Z,           0, 0,   0,  0,  0,  1, 1, 32'hDEADBEEF, 0, 0, Z);
    drive("idle3",       0, 0, Z,     Z,            0, 0, Z,     Z,           0, 0,   0,  0,  0,  1, 0, Z,            0, 0, Z);
    // Lock mode.
    drive("lock_req",    1, 0, 32'h10, Z,           0, 0, Z,     Z,           1, 0,   0,  0,  0,  1, 1, 32'hDEADBEEF, 0, 0, Z);
    drive("locked",      1, 0, 32'h10, Z,           0, 0, Z,     Z,           1, 0,   1,  0,  1,  1, 0, Z,            0, 0, Z);
    drive("lock_wr",     1, 0, 32'h10, Z,           1, 1, 32'h30, 32'hA5A5A5A5, 1, 0, 1,  1,  1,  2, 0, Z,            1, 0, Z);
    drive("unlock_req",  1, 0, 32'h10, Z,           0, 0, Z,     Z,           0, 0,   1,  0,  1,  3, 0, Z,            0, 0, Z);
    drive("unlocked",    1, 0, 32'h10, Z,           0, 0, Z,     Z,           0, 0,   0,  0,  0,  4, 1, 32'hDEADBEEF, 0, 0, Z);
    drive("ldr_rd30",    0, 0, Z,     Z,            1, 0, 32'h30, Z,          0, 0,   0,  0,  0,  4, 0, Z,            1, 1, 32'hA5A5A5A5);
    drive("idle4",       0, 0, Z,     Z,            0, 0, Z,     Z,           0, 0,   0,  0,  0,  4, 0, Z,            0, 0, Z);
    // Reset asserted while wait_cnt=3: counting restarts from zero afterwards.
    drive("rc_w0",       1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 0,   0,  0,  0,  4, 0, Z,            0, 0, Z);
    drive("rc_w1",       1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 0,   0,  0,  0,  4, 0, Z,            0, 0, Z);
    drive("rc_w2",       1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 0,   0,  0,  0,  4, 0, Z,            0, 0, Z);
    drive("rc_w3_rst",   1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 1,   0,  0,  0,  4, 0, Z,            0, 0, Z);
    drive("rc_post0",    1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 0,   0,  0,  0,  0, 1, 32'hDEADBEEF, 0, 0, Z);
    drive("rc_post1",    1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 0,   0,  0,  0,  0, 0, Z,            0, 0, Z);
    drive("rc_post2",    1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 0,   0,  0,  0,  0, 0, Z,            0, 0, Z);
    drive("rc_post3",    1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 0,   0,  0,  0,  0, 0, Z,            0, 0, Z);
    drive("rc_post4",    1, 0, 32'h10, Z,           1, 0, 32'h20, Z,          0, 0,   1,  0,  0,  0, 0, Z,            1, 1, 32'h12345678);
    drive("idle5",       0, 0, Z,     Z,            0, 0, Z,     Z,           0, 0,   0,  0,  0,  1, 0, Z,            0, 0, Z);
    drive("idle6",       0, 0, Z,     Z,            0, 0, Z,     Z,           0, 0,   0,  0,  0,  1, 0, Z,            0, 0, Z);

    repeat (3) @(posedge clk);
    #1;
    check("pending acks at end", ack_q.size(), 32'd0);
    check("pending cycles at end", cyc_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
